// File: rtl/bounce_box.sv
// Bouncing-box pattern generator: moves a coloured square one STEP per frame and renders it.
// Optional macro BOUNCE_BORDER_EN draws a white one-pixel frame around the active area.
module bounce_box #(
    parameter int H    = 640,
    parameter int V    = 480,
    parameter int SIZE = 32,
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] X,
    input  logic [31:0] Y,
    input  logic        disp_enable,
    input  logic        vsync,
    input  logic        pause,
    output logic        r,
    output logic        g,
    output logic        b,
    output logic        bounce
);

    localparam logic [1:0] ST_WAIT   = 2'd0;
    localparam logic [1:0] ST_MOVE_X = 2'd1;
    localparam logic [1:0] ST_MOVE_Y = 2'd2;

    localparam logic [15:0] LIM_X = 16'(H - SIZE);
    localparam logic [15:0] LIM_Y = 16'(V - SIZE);

    logic [1:0]  r_state;
    logic [15:0] r_box_x;
    logic [15:0] r_box_y;
    logic        r_dir_x;
    logic        r_dir_y;
    logic        r_hit_x;
    logic [2:0]  r_col;
    logic        r_vsync_d;
    logic        r_bounce;
    logic [2:0]  r_rgb_p1;

    logic        w_frame_edge;
    logic [17:0] w_step_x;
    logic [17:0] w_step_y;
    logic        w_inside;
    logic [2:0]  w_pix;

    // Returns {hit, new_dir, new_pos}; the wall clamps the position and reverses direction.
    function automatic logic [17:0] step_axis(input logic [15:0] pos, input logic dir,
                                              input logic [15:0] limit);
        if (dir) begin
            if (({16'd0, pos} + 32'(STEP)) > {16'd0, limit})
                return {1'b1, 1'b0, limit};
            else
                return {1'b0, 1'b1, pos + 16'(STEP)};
        end else begin
            if ({16'd0, pos} < 32'(STEP))
                return {1'b1, 1'b1, 16'd0};
            else
                return {1'b0, 1'b0, pos - 16'(STEP)};
        end
    endfunction

    assign w_frame_edge = r_vsync_d & ~vsync;
    assign w_step_x     = step_axis(r_box_x, r_dir_x, LIM_X);
    assign w_step_y     = step_axis(r_box_y, r_dir_y, LIM_Y);

    assign w_inside = (X >= {16'd0, r_box_x}) && (X < ({16'd0, r_box_x} + 32'(SIZE))) &&
                      (Y >= {16'd0, r_box_y}) && (Y < ({16'd0, r_box_y} + 32'(SIZE)));

    always_comb begin
        w_pix = 3'b000;
        if (disp_enable) begin
            if (w_inside)
                w_pix = r_col;
`ifdef BOUNCE_BORDER_EN
            else if ((X == 32'd0) || (X == 32'(H - 1)) || (Y == 32'd0) || (Y == 32'(V - 1)))
                w_pix = 3'b111;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_WAIT;
            r_box_x   <= 16'd0;
            r_box_y   <= 16'd0;
            r_dir_x   <= 1'b1;
            r_dir_y   <= 1'b1;
            r_hit_x   <= 1'b0;
            r_col     <= 3'b100;
            r_vsync_d <= 1'b0;
            r_bounce  <= 1'b0;
            r_rgb_p1  <= 3'b000;
        end else begin
            r_vsync_d <= vsync;
            r_bounce  <= 1'b0;
            r_rgb_p1  <= w_pix;
            case (r_state)
                ST_WAIT: begin
                    if (w_frame_edge && !pause)
                        r_state <= ST_MOVE_X;
                end
                ST_MOVE_X: begin
                    {r_hit_x, r_dir_x, r_box_x} <= w_step_x;
                    r_state <= ST_MOVE_Y;
                end
                ST_MOVE_Y: begin
                    {r_dir_y, r_box_y} <= w_step_y[16:0];
                    // One colour step per frame even when both walls are hit together.
                    if (r_hit_x || w_step_y[17]) begin
                        r_bounce <= 1'b1;
                        r_col    <= {r_col[0], r_col[2:1]};
                    end
                    r_state <= ST_WAIT;
                end
                default: r_state <= ST_WAIT;
            endcase
        end
    end

    assign {r, g, b} = r_rgb_p1;
    assign bounce    = r_bounce;

endmodule

// File: tb/tb_bounce_box.sv
// Directed + randomized bench for bounce_box against a per-frame arithmetic model.
// Build with BOUNCE_BORDER_EN defined or not; border expectations follow the macro.
module tb_bounce_box;

    localparam int H = 640, V = 480, SIZE = 32, STEP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] X, Y;
    logic        disp_enable, vsync, pause;
    logic        r, g, b, bounce;

    int checks = 0;
    int failures = 0;
    int total_bounce = 0;

    int mx, my, mcol;
    bit mdx, mdy;

    bounce_box #(.H(H), .V(V), .SIZE(SIZE), .STEP(STEP)) dut (
        .clk(clk), .rst(rst), .X(X), .Y(Y), .disp_enable(disp_enable),
        .vsync(vsync), .pause(pause), .r(r), .g(g), .b(b), .bounce(bounce)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mdx = 1; mdy = 1; mcol = 0;
    endtask

    function automatic logic [2:0] model_rgb(input int x, input int y, input bit de);
        if (!de) return 3'b000;
        if (x >= mx && x < mx + SIZE && y >= my && y < my + SIZE) return 3'b100 >> mcol;
`ifdef BOUNCE_BORDER_EN
        if (x == 0 || x == H - 1 || y == 0 || y == V - 1) return 3'b111;
`endif
        return 3'b000;
    endfunction

    // One frame of motion in plain arithmetic; returns whether any wall was touched.
    task automatic model_move(output bit hit);
        hit = 0;
        if (pause) return;
        if (mdx) begin
            if (mx + STEP > H - SIZE) begin mx = H - SIZE; mdx = 0; hit = 1; end
            else mx += STEP;
        end else begin
            if (mx < STEP) begin mx = 0; mdx = 1; hit = 1; end
            else mx -= STEP;
        end
        if (mdy) begin
            if (my + STEP > V - SIZE) begin my = V - SIZE; mdy = 0; hit = 1; end
            else my += STEP;
        end else begin
            if (my < STEP) begin my = 0; mdy = 1; hit = 1; end
            else my -= STEP;
        end
        if (hit) mcol = (mcol + 1) % 3;
    endtask

    task automatic probe_exp(input string tag, input int x, input int y, input bit de,
                             input logic [2:0] exp);
        X = 32'(x); Y = 32'(y); disp_enable = de;
        tick();
        check(tag, {r, g, b}, exp);
    endtask

    task automatic probe(input string tag, input int x, input int y, input bit de);
        probe_exp(tag, x, y, de, model_rgb(x, y, de));
    endtask

    task automatic probe_box();
        probe("box_tl", mx, my, 1);
        probe("box_br", mx + SIZE - 1, my + SIZE - 1, 1);
        probe("box_right", mx + SIZE, my, 1);
        probe("box_below", mx, my + SIZE, 1);
        if (mx > 0) probe("box_left", mx - 1, my, 1);
    endtask

    // A falling vsync edge, optionally with a second edge while the move is in flight.
    task automatic frame(input bit extra_edge);
        bit hit;
        int cnt;
        cnt = 0;
        vsync = 1'b0; tick(); cnt += int'(bounce);
        vsync = 1'b1; tick(); cnt += int'(bounce);
        if (extra_edge) vsync = 1'b0;
        tick(); cnt += int'(bounce);
        vsync = 1'b1; tick(); cnt += int'(bounce);
        tick(); cnt += int'(bounce);
        model_move(hit);
        total_bounce += cnt;
        check("bounce_per_frame", cnt, hit ? 1 : 0);
    endtask

    int frames;
    int saved_bounce;

    initial begin
        rst = 1'b1; pause = 1'b0; vsync = 1'b1; disp_enable = 1'b0; X = '0; Y = '0;
        model_reset();

        for (int i = 0; i < 2; i++) begin
            X = $urandom; Y = $urandom; disp_enable = 1'($urandom);
            vsync = 1'($urandom); pause = 1'($urandom);
            tick();
            check("reset_rgb", {r, g, b}, 3'b000);
            check("reset_bounce", bounce, 1'b0);
        end
        rst = 1'b0; pause = 1'b0; vsync = 1'b1;
        tick();

        probe_exp("render_in", 10, 10, 1, 3'b100);
        probe_exp("render_out", 32, 10, 1, 3'b000);
        probe_exp("render_blank", 10, 10, 0, 3'b000);
        probe_box();

        frame(0);
        frames = 1;
        probe_exp("moved_old_corner", 3, 3, 1, 3'b000);
        probe_exp("moved_new_corner", 35, 35, 1, 3'b100);

        while (frames < 113) begin
            frame((frames % 7) == 3);
            frames++;
            if ((frames % 10) == 0) begin
                probe("rand_probe", mx + int'($urandom_range(0, SIZE + 8)) - 4,
                      my + int'($urandom_range(0, SIZE + 8)), 1);
            end
        end
        check("bounces_after_113", total_bounce, 1);
        probe_exp("green_at_y448", mx, 448, 1, 3'b010);
        probe_exp("above_y448", mx, 447, 1, 3'b000);
        probe_box();

        while (frames < 153) begin
            frame(0);
            frames++;
        end
        check("bounces_after_153", total_bounce, 2);
        probe_exp("blue_at_x608", 608, my, 1, 3'b001);
        probe_exp("left_of_x608", 607, my, 1, 3'b000);
        probe_box();

        pause = 1'b1;
        saved_bounce = total_bounce;
        for (int i = 0; i < 5; i++) frame(0);
        check("pause_no_bounce", total_bounce, saved_bounce);
        probe_box();
        pause = 1'b0;

`ifdef BOUNCE_BORDER_EN
        probe_exp("border_right", 639, 200, 1, 3'b111);
`else
        probe_exp("border_right", 639, 200, 1, 3'b000);
`endif
        probe("border_top", 100, 0, 1);

        vsync = 1'b0; tick();
        rst = 1'b1; tick();
        check("rst_in_move_rgb", {r, g, b}, 3'b000);
        check("rst_in_move_bounce", bounce, 1'b0);
        rst = 1'b0;
        model_reset();
        tick(); tick(); tick();
        check("no_edge_after_rst", bounce, 1'b0);
        vsync = 1'b1; tick();
        probe_box();
        probe_exp("red_after_rst", 10, 10, 1, 3'b100);

        for (int i = 0; i < 30; i++) begin
            pause = ($urandom_range(0, 3) == 0);
            frame(1'($urandom));
            probe("rand_after", mx + int'($urandom_range(0, SIZE + 4)),
                  my + int'($urandom_range(0, SIZE + 4)) , 1'($urandom_range(0, 7) != 0));
        end
        pause = 1'b0;
        probe_box();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
